seq_approx_mult: RTL and testbench

- Iterative shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Accumulator adder built from the team's 4-bit CLA blocks.
- Runtime-selectable approximate mode truncates the low APPROX_COLS partial-product columns. This trades accuracy for switching activity.
- Intended as the sequential, area-lean companion to the combinational Dadda multipliers. Shares their exact/approximate error-characterisation flow.

---
 rtl/seq_approx_mult.sv | 164 ++++++++++++++++
 tb/tb_seq_approx_mult.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_approx_mult.sv
// seq_approx_mult
//   Iterative shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
//   It adds one partial product per cycle into an accumulator through a
//   chain of 4-bit carry-lookahead blocks. In approximate mode the low
//   APPROX_COLS columns of every partial product are dropped before the add.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operands/mode valid (sampled only in IDLE)
//   in_ready   high in IDLE: the block can accept operands
//   in_a       multiplicand
//   in_b       multiplier
//   in_approx  1 = approximate mode, 0 = exact
//   out_valid  high in DONE: product is valid
//   out_ready  consumer accepts product
//   product    result, held until the next completion or reset
//   busy       high in RUN or DONE
module seq_approx_mult #(
  parameter int WIDTH       = 16,
  parameter int APPROX_COLS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_approx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW   = 2 * WIDTH;
  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int NBLK = PW / 4;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("seq_approx_mult: WIDTH must be a multiple of 4 and at least 4");
  end
  if (APPROX_COLS < 0 || APPROX_COLS > PW) begin : g_bad_cols
    $error("seq_approx_mult: APPROX_COLS must lie in 0..2*WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              approx_q, approx_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     product_q, product_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [PW-1:0]     low_mask;
  logic [PW-1:0]     pp_raw;
  logic [PW-1:0]     pp;
  logic [PW-1:0]     sum;
  logic [NBLK-1:0]   carry;

  // Mask of the columns that approximate mode discards.
  for (genvar gi = 0; gi < PW; gi++) begin : g_mask
    assign low_mask[gi] = (gi < APPROX_COLS);
  end

  assign pp_raw = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
  assign pp     = approx_q ? (pp_raw & ~low_mask) : pp_raw;

  // Accumulator adder: 4-bit CLA blocks rippling block carries.
  // The top block has no carry-out, because the running sum of unsigned
  // partial products always fits in 2*WIDTH bits.
  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < NBLK; gi++) begin : g_cla
    logic [3:0] x, y, p, c;
    logic [2:0] g;

    assign x = acc_q[4*gi +: 4];
    assign y = pp[4*gi +: 4];
    assign p = x ^ y;
    assign g = x[2:0] & y[2:0];

    assign c[0] = carry[gi];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);

    assign sum[4*gi +: 4] = p ^ c;

    if (gi < NBLK - 1) begin : g_cout
      assign carry[gi+1] = (x[3] & y[3]) | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                         | (p[3] & p[2] & p[1] & g[0])
                         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    approx_d  = approx_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = in_a;
          b_d      = in_b;
          approx_d = in_approx;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          product_d = sum;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      approx_q  <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      approx_q  <= approx_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_approx_mult.sv
// Testbench for seq_approx_mult (WIDTH=16, APPROX_COLS=8).
// Table of directed vectors with hand-computed products, plus hand-written
// sequences for backpressure, mid-operation reset and back-to-back streaming.
// Inputs are driven and outputs sampled on the falling edge.
module tb_seq_approx_mult;

  localparam int W  = 16;
  localparam int AC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_approx;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] product;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_approx_mult #(.WIDTH(W), .APPROX_COLS(AC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_approx (in_approx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        approx;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, req);
    end
  endtask

  // Reference: exact = arithmetic product; approx = sum of partial products
  // with columns below AC cleared.
  function automatic logic [31:0] ref_mult(input logic [15:0] a, input logic [15:0] b,
                                           input logic ap);
    logic [31:0] r;
    logic [31:0] term;
    if (!ap) return 32'(a) * 32'(b);
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (b[i]) begin
        term = 32'(a) << i;
        term = (term >> AC) << AC;
        r    = r + term;
      end
    end
    return r;
  endfunction

  // Called at a falling edge; waits for in_ready, presents the operands for
  // one rising edge, and returns at the falling edge right after the accept.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic ap);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    in_a      = a;
    in_b      = b;
    in_approx = ap;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  // Counts rising edges since the accept until out_valid is seen (bounded).
  task automatic wait_done(input int start, output int edges);
    edges = start;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    int   edges;
    int   acc_cyc[3];
    logic [15:0] ra, rb;
    logic rap;

    vecs[0]  = '{"exact_max",    16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vecs[1]  = '{"approx_max",   16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFDF900};
    vecs[2]  = '{"zero",         16'h1234, 16'h0000, 1'b0, 32'h00000000};
    vecs[3]  = '{"ident_exact",  16'h1234, 16'h0001, 1'b0, 32'h00001234};
    vecs[4]  = '{"ident_approx", 16'h1234, 16'h0001, 1'b1, 32'h00001200};
    vecs[5]  = '{"ff_sq_exact",  16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01};
    vecs[6]  = '{"ff_sq_approx", 16'h00FF, 16'h00FF, 1'b1, 32'h0000F700};
    vecs[7]  = '{"small_approx", 16'h0003, 16'h0005, 1'b1, 32'h00000000};
    vecs[8]  = '{"msb_exact",    16'h8000, 16'h8000, 1'b0, 32'h40000000};
    vecs[9]  = '{"msb_approx",   16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vecs[10] = '{"abcd_ff",      16'hABCD, 16'h00FF, 1'b0, 32'h00AB2133};
    vecs[11] = '{"shift_approx", 16'h1234, 16'h0010, 1'b1, 32'h00012300};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_product",   product,        32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors: product, fixed latency, handshake back to IDLE.
    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].approx);
      chk({vecs[i].name, "_busy"},  32'(busy),     32'd1);
      chk({vecs[i].name, "_ready"}, 32'(in_ready), 32'd0);
      wait_done(0, edges);
      chk({vecs[i].name, "_latency"}, 32'(edges), 32'd16);
      chk({vecs[i].name, "_product"}, product, vecs[i].exp);
      $display("vec %0s a=0x%h b=0x%h approx=%0d product=0x%h latency=%0d",
               vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].approx, product, edges);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({vecs[i].name, "_idle_ready"}, 32'(in_ready),  32'd1);
      chk({vecs[i].name, "_idle_valid"}, 32'(out_valid), 32'd0);
    end

    // Backpressure, with junk operands offered while the operation runs.
    start_op(16'h1234, 16'h0010, 1'b0);
    for (int e = 0; e < 10; e++) begin
      in_valid  = 1'b1;
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      in_approx = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_done(10, edges);
    chk("bp_latency", 32'(edges), 32'd16);
    for (int k = 0; k < 5; k++) begin
      chk("bp_product",   product,         32'h00012340);
      chk("bp_out_valid", 32'(out_valid),  32'd1);
      chk("bp_in_ready",  32'(in_ready),   32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_ready", 32'(in_ready),  32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_hold_product",  product,        32'h00012340);
    $display("backpressure product=0x%h", product);

    // Reset in the middle of RUN, with new operands offered during RUN.
    start_op(16'hABCD, 16'h00FF, 1'b0);
    for (int e = 1; e <= 6; e++) begin
      in_valid = 1'b1;
      in_a     = 16'h1111;
      in_b     = 16'h2222;
      @(negedge clk);
    end
    chk("midrst_busy_before",  32'(busy),     32'd1);
    chk("midrst_ready_before", 32'(in_ready), 32'd0);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy",      32'(busy),      32'd0);
    chk("midrst_product",   product,        32'd0);
    @(negedge clk);
    chk("midrst_stays_idle", 32'(busy), 32'd0);
    $display("mid-op reset product=0x%h busy=%0d", product, busy);

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      while (!in_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rap = k[0];
      in_a      = ra;
      in_b      = rb;
      in_approx = rap;
      acc_cyc[k] = cyc;
      @(negedge clk);
      if (k == 2) in_valid = 1'b0;
      wait_done(0, edges);
      chk("b2b_latency", 32'(edges), 32'd16);
      chk("b2b_product", product, ref_mult(ra, rb, rap));
      $display("b2b %0d a=0x%h b=0x%h approx=%0d product=0x%h", k, ra, rb, rap, product);
      @(negedge clk);
    end
    chk("b2b_spacing_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd18);
    chk("b2b_spacing_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd18);
    chk("b2b_final_idle", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
